base_gather: RTL
================

Name: base_gather

Overview:
- Packs a stream of narrow big-endian beats into one wide big-endian word for the next stage.
- Sits directly upstream of the bit-order conversion stage.
- Collects up to `beats` input beats of `width` bits each. The first beat lands in the most-significant slice, bits [0:width-1].
- Emits a word when it is full or when a beat flagged end-of-frame arrives; partial words are zero-filled.
- Uses a valid/ready handshake on both sides, with a double-buffered accumulator/output register so it sustains one beat per cycle.

Parameters:
- width, 8, bits per input beat.
- beats, 4, beats per output word (≥2).
- cnt_width, 3, width of beat-count fields; must hold the value `beats`.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_v  input  1  input beat valid.
- o_r  output  1  input ready; a beat transfers when i_v & o_r.
- i_d  input  [0:width-1]  input beat data, big-endian.
- i_e  input  1  end-of-frame; qualifies i_v; closes the current word after this beat.
- o_v  output  1  output word valid.
- i_r  input  1  downstream ready; a word transfers when o_v & i_r.
- o_d  output  [0:width*beats-1]  packed word; beat k occupies [k*width : k*width+width-1].
- o_cnt  output  [0:cnt_width-1]  number of valid beats in o_d (1..beats).
- o_e  output  1  word was closed by i_e.

Behaviour:
- Reset values, asserted asynchronously and held while reset is high:
  - o_v=0, o_d=0, o_cnt=0, o_e=0, o_r=1.
  - Accumulator data=0, accumulator count=0, acc_done=0.
- Internal state:
  - Accumulator register, same width as o_d.
  - acc_cnt (0..beats-1 while filling).
  - acc_done: accumulator holds a completed word awaiting the output register.
  - Output register driving o_d/o_cnt/o_e/o_v.
- o_r = ~acc_done. o_r is purely registered, with no combinational path from i_v, i_e or i_r.
- Accepted beat, not completing (acc_cnt < beats-1 and i_e=0):
  - Written into slice acc_cnt.
  - acc_cnt increments.
- Completing beat (acc_cnt == beats-1, or i_e=1):
  - Forms the word: accumulator slices plus the new beat, slices above the new beat zero.
  - Count = acc_cnt+1; e = i_e.
  - If the output is free this cycle (o_v==0, or o_v & i_r), the word loads into the output register next edge: o_v=1, and the accumulator clears (count 0, data 0).
  - Otherwise the word stays in the accumulator and acc_done sets. o_r drops on the next cycle.
- Pending word: while acc_done=1, when the output is free (o_v==0 or o_v & i_r), the accumulator moves to the output register, acc_done clears and o_r rises the following cycle.
- Output drain: o_v & i_r with nothing loading → o_v clears; o_d/o_cnt/o_e hold their last values. Verification must not check them while o_v=0.
- Simultaneous drain and load in the same cycle: the new word replaces the old one, o_v stays 1, and there is no bubble.
- Latency: completing beat accepted at cycle N → o_v high at N+1 when the output is free.
- Throughput: with i_r held high, one beat accepted per cycle indefinitely.
- i_e on the first beat of a word → single-beat word, o_cnt=1.
- i_e on beat beats-1 → full word with o_e=1.
- o_d is stable while o_v & ~i_r. No input beat is dropped or reordered.
- Reset mid-word discards the partial accumulator and any pending or output word.
- i_v while o_r=0 is ignored, and upstream must hold the beat.

Test Plan:
- Reset: assert reset asynchronously mid-cycle → o_v=0, o_d=0, o_cnt=0, o_r=1 immediately. After release, 4 beats 0x11,0x22,0x33,0x44 with i_r=1 → o_d=0x11223344, o_cnt=4, o_e=0, o_v high one cycle after the 4th beat.
- Partial frame: beats 0xAA, 0xBB (i_e=1 on 2nd) → o_d=0xAABB0000, o_cnt=2, o_e=1; i_e on a single beat 0x5C → o_d=0x5C000000, o_cnt=1.
- Backpressure: i_r=0, send 8 beats 0x01..0x08 back-to-back → output holds 0x01020304; o_r drops after the 8th beat is accepted, with the second word pending. Raise i_r → 0x01020304 then 0x05060708, each for exactly one handshake; o_r returns to 1.
- Streaming: i_r=1, 64 continuous beats with i_v=1 → o_r never drops; 16 words in order, one every 4 cycles, no gaps beyond packing.
- Simultaneous: word in output with i_r=1 on the same cycle the next word completes → o_v stays high, new data appears next cycle, no loss.
- Random: random i_v/i_r/i_e, 10k beats → scoreboard match of data, o_cnt and o_e; o_d stable while o_v & ~i_r; no beat lost or duplicated.

Source files
------------

// File: rtl/base_gather.sv
// base_gather: packs narrow big-endian beats into one wide big-endian word.
// Double-buffered (accumulator + output register) so it sustains one beat per cycle.
module base_gather #(
  parameter int width     = 8,
  parameter int beats     = 4,
  parameter int cnt_width = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_v,
  output logic                     o_r,
  input  logic [0:width-1]         i_d,
  input  logic                     i_e,
  output logic                     o_v,
  input  logic                     i_r,
  output logic [0:width*beats-1]   o_d,
  output logic [0:cnt_width-1]     o_cnt,
  output logic                     o_e
);

  localparam int DW = width * beats;
  typedef logic [cnt_width-1:0] cnt_t;

  logic [0:DW-1] acc_q, acc_d;
  cnt_t          acc_cnt_q, acc_cnt_d;
  logic          acc_done_q, acc_done_d;
  logic          acc_e_q, acc_e_d;
  logic          ov_q, ov_d;
  logic [0:DW-1] od_q, od_d;
  cnt_t          ocnt_q, ocnt_d;
  logic          oe_q, oe_d;

  logic          out_free;
  logic          take;
  logic          last;
  logic [0:DW-1] word;
  cnt_t          cnt_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= '0;
      acc_cnt_q  <= '0;
      acc_done_q <= 1'b0;
      acc_e_q    <= 1'b0;
      ov_q       <= 1'b0;
      od_q       <= '0;
      ocnt_q     <= '0;
      oe_q       <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_done_q <= acc_done_d;
      acc_e_q    <= acc_e_d;
      ov_q       <= ov_d;
      od_q       <= od_d;
      ocnt_q     <= ocnt_d;
      oe_q       <= oe_d;
    end
  end

  always_comb begin
    out_free = ~ov_q | i_r;
    take     = i_v & ~acc_done_q;
    last     = take & (i_e | (acc_cnt_q == cnt_t'(beats - 1)));
    cnt_inc  = acc_cnt_q + cnt_t'(1);

    // Slices above the current one are already zero: the accumulator
    // is cleared whenever a word leaves it.
    word = acc_q;
    for (int k = 0; k < beats; k++) begin
      if (cnt_t'(k) == acc_cnt_q) word[k*width +: width] = i_d;
    end

    acc_d      = acc_q;
    acc_cnt_d  = acc_cnt_q;
    acc_done_d = acc_done_q;
    acc_e_d    = acc_e_q;
    ov_d       = ov_q & ~i_r;
    od_d       = od_q;
    ocnt_d     = ocnt_q;
    oe_d       = oe_q;

    if (acc_done_q) begin
      if (out_free) begin
        ov_d       = 1'b1;
        od_d       = acc_q;
        ocnt_d     = acc_cnt_q;
        oe_d       = acc_e_q;
        acc_d      = '0;
        acc_cnt_d  = '0;
        acc_done_d = 1'b0;
        acc_e_d    = 1'b0;
      end
    end else if (last) begin
      if (out_free) begin
        ov_d      = 1'b1;
        od_d      = word;
        ocnt_d    = cnt_inc;
        oe_d      = i_e;
        acc_d     = '0;
        acc_cnt_d = '0;
      end else begin
        acc_d      = word;
        acc_cnt_d  = cnt_inc;
        acc_done_d = 1'b1;
        acc_e_d    = i_e;
      end
    end else if (take) begin
      acc_d     = word;
      acc_cnt_d = cnt_inc;
    end
  end

  assign o_r   = ~acc_done_q;
  assign o_v   = ov_q;
  assign o_d   = od_q;
  assign o_cnt = ocnt_q;
  assign o_e   = oe_q;

endmodule
